// File: rtl/pwm_pkg.sv
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared state encoding, sample type and default sizing for
//                the PWM sample scheduler.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_MUTE = 2'd3
    } state_t;

    typedef logic signed [15:0] sample_t;

    localparam int         c_default_period = 256;
    localparam int         c_default_depth  = 4;
    localparam logic [4:0] c_gain_unity     = 5'd16;

endpackage

`default_nettype wire

// File: rtl/pwm_sample_fifo.sv
// ============================================================================
//  Module      : pwm_sample_fifo
//  Description : Show-ahead sample FIFO with flush and occupancy count.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pwm_sample_fifo
    import pwm_pkg::*;
#(
    parameter  int DEPTH = c_default_depth,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [15:0]   push_data,
    input  logic          pop,
    output logic [15:0]   head,
    output logic [LW-1:0] level
);

    localparam int            c_aw   = $clog2(DEPTH);
    localparam logic [LW-1:0] c_full = LW'(DEPTH);

    sample_t         r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [LW-1:0]   r_level;

    logic w_push_ok;
    logic w_pop_ok;

    // An empty FIFO ignores pop, so a simultaneous push is stored, not bypassed.
    assign w_push_ok = push && (r_level != c_full);
    assign w_pop_ok  = pop && (r_level != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign level = r_level;

endmodule

`default_nettype wire

// File: rtl/pwm_sample_sched.sv
// ============================================================================
//  Module      : pwm_sample_sched
//  Description : Frame-paced sample scheduler feeding a PWM modulator.
//                Define PWM_SCHED_RAMP_EN for the soft-mute gain ramp.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pwm_sample_sched
    import pwm_pkg::*;
#(
    parameter  int PERIOD = c_default_period,
    parameter  int DEPTH  = c_default_depth,
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          mute,
    input  logic          in_valid,
    input  logic [15:0]   in_data,
    output logic          in_ready,
    output logic [15:0]   pcm_out,
    output logic          frame_start,
    output logic          underrun,
    output logic [LW-1:0] level
);

    localparam int              c_cw   = $clog2(PERIOD);
    localparam logic [c_cw-1:0] c_last = c_cw'(PERIOD - 1);
    localparam logic [LW-1:0]   c_half = LW'(DEPTH / 2);
    localparam logic [LW-1:0]   c_full = LW'(DEPTH);

    state_t          r_state;
    logic [c_cw-1:0] r_cnt;
    sample_t         r_pcm;
    logic            r_frame_start;
    logic            r_underrun;

    logic [LW-1:0]   w_level;
    sample_t         w_head;
    sample_t         w_pcm_fetch;
    logic            w_fetch;
    logic            w_fill_done;
    logic            w_to_mute;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;

    assign w_fetch     = (r_cnt == c_last);
    assign w_fill_done = (r_state == ST_FILL) && (w_level >= c_half);
    assign w_to_mute   = ((r_state == ST_RUN) || (r_state == ST_MUTE)) && mute;
    assign w_empty     = (w_level == '0);

    assign in_ready = (r_state != ST_IDLE) && (w_level < c_full);
    assign w_push   = in_valid && in_ready;
    assign w_flush  = !enable || (r_state == ST_IDLE);
    assign w_pop    = enable && w_fetch &&
                      ((r_state == ST_RUN) || (r_state == ST_MUTE) || w_fill_done);

    pwm_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_flush),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .head      (w_head),
        .level     (w_level)
    );

`ifdef PWM_SCHED_RAMP_EN
    logic [4:0]         r_gain;
    logic [4:0]         w_gain_next;
    logic signed [21:0] w_prod;

    // Gain follows the state being entered, so the first muted frame is already attenuated.
    always_comb begin
        w_gain_next = r_gain;
        if (w_to_mute) begin
            if (r_gain != 5'd0) begin
                w_gain_next = r_gain - 5'd1;
            end
        end else if (r_gain != c_gain_unity) begin
            w_gain_next = r_gain + 5'd1;
        end
    end

    assign w_prod      = w_head * $signed({1'b0, w_gain_next});
    assign w_pcm_fetch = w_empty ? r_pcm : sample_t'(w_prod >>> 4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain <= c_gain_unity;
        end else if (w_pop) begin
            r_gain <= w_gain_next;
        end
    end
`else
    assign w_pcm_fetch = w_to_mute ? sample_t'(0) : (w_empty ? r_pcm : w_head);
`endif

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_pcm         <= '0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (r_state == ST_IDLE) begin
                // Counter stays at 0, so the first FILL cycle is a frame boundary.
                r_state       <= ST_FILL;
                r_frame_start <= 1'b1;
            end else begin
                r_cnt         <= r_cnt + c_cw'(1);
                r_frame_start <= w_fetch;
                if (w_fetch) begin
                    case (r_state)
                        ST_FILL: begin
                            if (w_fill_done) begin
                                r_state <= ST_RUN;
                                r_pcm   <= w_pcm_fetch;
                            end
                        end
                        ST_RUN, ST_MUTE: begin
                            r_state    <= mute ? ST_MUTE : ST_RUN;
                            r_pcm      <= w_pcm_fetch;
                            r_underrun <= (r_state == ST_RUN) && w_empty;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign pcm_out     = r_pcm;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
    assign level       = w_level;

endmodule

`default_nettype wire

// File: tb/tb_pwm_sample_sched.sv
// ============================================================================
//  Module      : tb_pwm_sample_sched
//  Description : Directed scoreboard bench for pwm_sample_sched.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_sample_sched;

    localparam int PERIOD = 256;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mute;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] pcm_out;
    logic        frame_start;
    logic        underrun;
    logic [2:0]  level;

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [15:0] q[$];

    pwm_sample_sched #(
        .PERIOD (PERIOD),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mute        (mute),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .pcm_out     (pcm_out),
        .frame_start (frame_start),
        .underrun    (underrun),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 2 * PERIOD);
        chk({tag, "_fs"}, {31'd0, frame_start}, 32'd1);
    endtask

    function automatic logic [15:0] pop_exp();
        if (q.size() == 0) return 16'hDEAD;
        return q.pop_front();
    endfunction

    function automatic logic [15:0] ramp_exp(input int g);
        int p;
        p = (32752 * g) >>> 4;
        return p[15:0];
    endfunction

    initial begin
        logic [15:0] nxt;
        logic [15:0] e;
        logic        rdy;
        int          since;
        int          frames;
        int          guard;
        int          g;
        int          seen;

        // Reset with every other input active.
        rst = 1'b1; enable = 1'b1; mute = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
        repeat (3) tick();
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_pcm", {16'd0, pcm_out}, 32'd0);
        chk("rst_fs", {31'd0, frame_start}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);

        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("fill_ready", {31'd0, in_ready}, 32'd1);

        // Two samples then the first fetch moves FILL to RUN.
        in_valid = 1'b1; in_data = 16'h1000; tick(); q.push_back(16'h1000);
        in_data = 16'h2000; tick(); q.push_back(16'h2000);
        in_valid = 1'b0;
        chk("fill_level", {29'd0, level}, 32'd2);
        wait_fs("first");
        chk("first_pcm", {16'd0, pcm_out}, {16'd0, pop_exp()});
        chk("first_level", {29'd0, level}, 32'd1);
        wait_fs("second");
        chk("second_pcm", {16'd0, pcm_out}, {16'd0, pop_exp()});

        // Drained FIFO: underrun pulse, output holds.
        wait_fs("urun");
        chk("urun_pulse", {31'd0, underrun}, 32'd1);
        chk("urun_pcm", {16'd0, pcm_out}, 32'h2000);
        chk("urun_level", {29'd0, level}, 32'd0);
        tick();
        chk("urun_once", {31'd0, underrun}, 32'd0);

        // Producer always valid: FIFO stays full, stream order preserved.
        nxt = 16'h0100; since = 2; frames = 0; guard = 0;
        while (frames < 8 && guard < 10 * PERIOD) begin
            in_valid = 1'b1; in_data = nxt; rdy = in_ready;
            tick();
            guard++; since++;
            if (rdy) begin
                q.push_back(nxt);
                nxt++;
            end
            if (frame_start) begin
                frames++;
                since = 0;
                e = pop_exp();
                chk("full_pcm", {16'd0, pcm_out}, {16'd0, e});
            end
            if (since == 128) begin
                chk("full_level", {29'd0, level}, 32'd4);
                chk("full_ready", {31'd0, in_ready}, 32'd0);
            end
        end
        in_valid = 1'b0;
        chk("full_frames", frames, 8);
        chk("full_count", {29'd0, level}, q.size());

        wait_fs("drain0");
        chk("drain0_pcm", {16'd0, pcm_out}, {16'd0, pop_exp()});
        chk("drain0_level", {29'd0, level}, 32'd2);

        // Push lands on the fetch edge at level 2.
        repeat (PERIOD - 1) tick();
        chk("pp_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = 16'h5A5A;
        tick();
        in_valid = 1'b0;
        chk("pp_fs", {31'd0, frame_start}, 32'd1);
        chk("pp_pcm", {16'd0, pcm_out}, {16'd0, pop_exp()});
        q.push_back(16'h5A5A);
        chk("pp_level", {29'd0, level}, 32'd2);
        wait_fs("pp1");
        chk("pp1_pcm", {16'd0, pcm_out}, {16'd0, pop_exp()});
        wait_fs("pp2");
        chk("pp2_pcm", {16'd0, pcm_out}, {16'd0, pop_exp()});
        chk("pp2_level", {29'd0, level}, q.size());

        // Constant sample, then mute for 17 frames and unmute.
        in_valid = 1'b1; in_data = 16'h7FF0;
        wait_fs("pre_mute");
        chk("pre_mute_pcm", {16'd0, pcm_out}, 32'h7FF0);
        mute = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            wait_fs("mute");
            g = (16 - k < 0) ? 0 : 16 - k;
`ifdef PWM_SCHED_RAMP_EN
            e = ramp_exp(g);
`else
            e = 16'h0000;
`endif
            chk($sformatf("mute_k%0d", k), {16'd0, pcm_out}, {16'd0, e});
        end
        mute = 1'b0;
        wait_fs("unmute");
`ifdef PWM_SCHED_RAMP_EN
        e = ramp_exp(1);
`else
        e = 16'h7FF0;
`endif
        chk("unmute_pcm", {16'd0, pcm_out}, {16'd0, e});

        // Disable mid-frame at counter 100.
        in_valid = 1'b0;
        repeat (100) tick();
        enable = 1'b0;
        tick();
        chk("dis_level", {29'd0, level}, 32'd0);
        chk("dis_pcm", {16'd0, pcm_out}, 32'd0);
        chk("dis_ready", {31'd0, in_ready}, 32'd0);
        chk("dis_fs", {31'd0, frame_start}, 32'd0);
        seen = 0;
        repeat (600) begin
            tick();
            if (frame_start) seen = 1;
        end
        chk("dis_no_fs", seen, 0);
        enable = 1'b1;
        tick();
        chk("reen_ready", {31'd0, in_ready}, 32'd1);
        chk("reen_pcm", {16'd0, pcm_out}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pwm_sample_sched.md
PWM_SAMPLE_SCHED -- requirements
Module: pwm_sample_sched

Interface
REQ-001 Parameter PERIOD, default 256, clocks per PWM frame; power of two, 4..65536.
REQ-002 Parameter DEPTH, default 4, sample FIFO entries; power of two, 2..16.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 enable  in  1  scheduler run request; 0 forces IDLE.
REQ-006 mute  in  1  mute request, sampled at frame boundaries only.
REQ-007 in_valid  in  1  producer sample valid.
REQ-008 in_data  in  16  signed PCM sample from synth.
REQ-009 in_ready  out  1  scheduler can accept; transfer when in_valid && in_ready.
REQ-010 pcm_out  out  16  signed sample driven to the PWM modulator.
REQ-011 frame_start  out  1  one-cycle pulse when the frame counter equals 0; the modulator latches pcm_out on this cycle.
REQ-012 underrun  out  1  one-cycle pulse when a frame fetch finds the FIFO empty in RUN.
REQ-013 level  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Frame counter SHALL count 0..PERIOD-1 and wrap, free-running in every state except IDLE, where it SHALL be held at 0.
REQ-015 Fetch cycle SHALL be counter == PERIOD-1; pcm_out SHALL update only on the fetch cycle, so it is stable when frame_start asserts on the following cycle.
REQ-016 in_ready SHALL equal (state != IDLE) && (level < DEPTH); a push while full SHALL be impossible, even if a pop occurs the same cycle.
REQ-017 Push and pop in the same cycle with level > 0 SHALL leave level unchanged; with level == 0 a pop SHALL NOT bypass the pushed sample (underrun, sample stored).
REQ-018 States: IDLE, FILL, RUN, MUTE.
REQ-019 IDLE: FIFO flushed, pcm_out = 0; enable=1 -> FILL.
REQ-020 FILL: accept only, no pops, pcm_out = 0; on a fetch cycle with level >= DEPTH/2 -> RUN (pop on that same fetch cycle).
REQ-021 RUN: each fetch cycle pops the head into pcm_out; if empty, pcm_out holds its last value, underrun pulses, and the state stays RUN.
REQ-022 RUN with mute=1 on a fetch cycle -> MUTE; MUTE with mute=0 on a fetch cycle -> RUN.
REQ-023 MUTE: FIFO keeps popping on fetch cycles (samples discarded), and the output follows REQ-029/REQ-030.
REQ-024 enable=0 in any state SHALL go to IDLE on the next cycle, flush the FIFO and zero pcm_out, even mid-frame.
REQ-025 Gain arithmetic SHALL use a signed 16x5-bit product, arithmetic right shift by 4, no saturation needed (gain <= 16).

Reset
REQ-026 rst SHALL set state IDLE, counter 0, level 0, pcm_out 0, frame_start 0, underrun 0, in_ready 0; gain SHALL be 16.
REQ-027 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-028 Macro PWM_SCHED_RAMP_EN selects the soft-mute ramp.
REQ-029 With PWM_SCHED_RAMP_EN: a 5-bit gain steps -1 per fetch cycle in MUTE (floor 0) and +1 per fetch cycle in RUN (ceiling 16); pcm_out = (sample*gain)>>>4.
REQ-030 Without PWM_SCHED_RAMP_EN: no gain register; pcm_out = 0 on fetch cycles in MUTE and the raw sample in RUN.

Structure
REQ-031 A shared package pwm_pkg SHALL hold the state enum, the sample typedef (signed 16) and the default PERIOD/DEPTH constants.
REQ-032 The FIFO SHALL be a sub-module pwm_sample_fifo (push, pop, flush, level); all other logic SHALL be in the top.

Verification
REQ-033 Reset, enable=1, push 2 samples 0x1000 and 0x2000 (DEPTH=4): first fetch -> RUN; pcm_out=0x1000 before the first frame_start after entry; 0x2000 one frame later.
REQ-034 Keep FIFO full at 4 with in_valid held: in_ready=0, level stays 4, no sample lost or duplicated over 8 frames.
REQ-035 RUN with FIFO drained: the next fetch gives an underrun pulse, pcm_out holds its last value (e.g. 0x2000), and level stays 0.
REQ-036 With RAMP_EN, sample 0x7FF0 constant: mute=1 gives gain stepping 16->0 over 16 frames, with pcm_out at frame k = (0x7FF0*(16-k))>>>4; without RAMP_EN, pcm_out=0 on the next fetch.
REQ-037 With PERIOD=256 and enable dropped at counter=100 in RUN: the next cycle shows IDLE, level=0, pcm_out=0, in_ready=0, and no frame_start until re-enabled.
REQ-038 Simultaneous push and pop at level=2: level remains 2 and FIFO order is preserved.
